bounce_sprite: RTL and testbench

BOUNCE_SPRITE -- requirements
Module: bounce_sprite

---
 rtl/bounce_sprite.sv | 110 +++++++++++
 tb/tb_bounce_sprite.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_sprite.sv
// bounce_sprite: square sprite that moves once per frame and bounces off, or wraps around, the visible raster edges
module bounce_sprite #(
   parameter int P_H_VISIBLE = 640,
   parameter int P_V_VISIBLE = 480,
   parameter int P_SIZE      = 10,
   parameter int P_START_X   = (P_H_VISIBLE - P_SIZE) / 2,
   parameter int P_START_Y   = (P_V_VISIBLE - P_SIZE) / 2,
   parameter bit P_WRAP      = 1'b0
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_HBlank,
   input  logic       i_VBlank,
   input  logic       i_HReset,
   input  logic       i_VReset,
   input  logic       i_Pause,
   input  logic [3:0] i_SpeedX,
   input  logic [3:0] i_SpeedY,
   output logic       o_Video,
   output logic [9:0] o_PosX,
   output logic [9:0] o_PosY,
   output logic       o_HitX,
   output logic       o_HitY
);
   localparam logic [10:0] L_H  = 11'(P_H_VISIBLE);
   localparam logic [10:0] L_V  = 11'(P_V_VISIBLE);
   localparam logic [10:0] L_SZ = 11'(P_SIZE);

   typedef enum logic {RUN, HOLD} state_t;

   state_t      state, state_nx;
   logic        upd, dir_x, dir_y, line_seen, in_x, in_y;
   logic [9:0]  pos_x, pos_y;
   logic [10:0] col, row, end_x, end_y;
   logic [11:0] nx_x, nx_y;

   // one axis step, returns {hit, dir, pos}; 11-bit math keeps sums from overflowing
   function automatic logic [11:0] step(input logic [9:0] pos, input logic dir, input logic [3:0] spd, input logic [10:0] lim);
      logic [10:0] p, s, sum, dif, hi;
      p = 11'(pos);
      s = 11'(spd);
      sum = p + s;
      dif = p - s;
      hi = lim - L_SZ;
      if (spd == 4'd0)
         return {1'b0, dir, pos};
      if (P_WRAP) begin
         if (dir)
            return (sum >= lim) ? {1'b1, dir, 10'(sum - lim)} : {1'b0, dir, 10'(sum)};
         return (p < s) ? {1'b1, dir, 10'(dif + lim)} : {1'b0, dir, 10'(dif)};
      end
      if (dir)
         return (sum >= hi) ? {2'b10, 10'(hi)} : {2'b01, 10'(sum)};
      return (p <= s) ? {2'b11, 10'd0} : {2'b00, 10'(dif)};
   endfunction

   always_comb begin
      state_nx = state;
      upd = 1'b0;
      case (state)
         RUN: begin
            state_nx = i_Pause ? HOLD : RUN;
            upd = i_VReset & ~i_Pause;
         end
         HOLD: state_nx = i_Pause ? HOLD : RUN;
      endcase
   end

   assign nx_x = step(pos_x, dir_x, i_SpeedX, L_H);
   assign nx_y = step(pos_y, dir_y, i_SpeedY, L_V);

   // in wrap mode the part of the sprite folded past the edge reappears at column/row 0
   always_comb begin
      end_x = 11'(pos_x) + L_SZ;
      end_y = 11'(pos_y) + L_SZ;
      in_x = (col >= 11'(pos_x) && col < end_x) || (P_WRAP && end_x > L_H && col < end_x - L_H);
      in_y = (row >= 11'(pos_y) && row < end_y) || (P_WRAP && end_y > L_V && row < end_y - L_V);
   end

   assign o_Video = ~i_HBlank & ~i_VBlank & in_x & in_y;
   assign o_PosX  = pos_x;
   assign o_PosY  = pos_y;

   always_ff @(posedge i_Clk or negedge i_Rst_n)
      if (!i_Rst_n) begin
         state <= RUN;
         col <= '0;
         row <= '0;
         line_seen <= 1'b0;
         pos_x <= 10'(P_START_X);
         pos_y <= 10'(P_START_Y);
         dir_x <= 1'b1;
         dir_y <= 1'b1;
         o_HitX <= 1'b0;
         o_HitY <= 1'b0;
      end else begin
         state <= state_nx;
         col <= i_HReset ? '0 : (i_HBlank ? col : col + 11'd1);
         row <= i_VReset ? '0 : ((i_HReset && line_seen) ? row + 11'd1 : row);
         line_seen <= i_HReset ? 1'b0 : (line_seen | (~i_HBlank & ~i_VBlank));
         o_HitX <= upd & nx_x[11];
         o_HitY <= upd & nx_y[11];
         if (upd) begin
            pos_x <= nx_x[9:0];
            dir_x <= nx_x[10];
            pos_y <= nx_y[9:0];
            dir_y <= nx_y[10];
         end
      end
endmodule

// File: tb/tb_bounce_sprite.sv
// tb_bounce_sprite: randomized scoreboard bench for three bounce_sprite configurations against a frame-level motion model
module tb_bounce_sprite;
   typedef struct packed {logic [9:0] x; logic [9:0] y; logic hx; logic hy;} exp_t;
   typedef exp_t [2:0] exp3_t;

   logic clk = 1'b0, rst_n = 1'b0, hb = 1'b1, vb = 1'b1, hr = 1'b0, vr = 1'b0, pause = 1'b0;
   logic [3:0] spx = '0, spy = '0;
   logic vid [3], hx [3], hy [3];
   logic [9:0] px [3], py [3];

   int H [3] = '{40, 40, 640};
   int V [3] = '{30, 30, 480};
   int S [3] = '{6, 6, 10};
   int W [3] = '{0, 1, 0};
   int mx [3], my [3], mdx [3], mdy [3];
   int cx = 0, cy = 0, n_cmp = 0, n_bad = 0;
   bit pp = 1'b0, vid_en = 1'b0;
   exp3_t q [$];
   exp3_t cur;

   always #5 clk = ~clk;

   bounce_sprite #(.P_H_VISIBLE(40), .P_V_VISIBLE(30), .P_SIZE(6), .P_WRAP(1'b0)) u0 (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_HBlank(hb), .i_VBlank(vb), .i_HReset(hr), .i_VReset(vr),
      .i_Pause(pause), .i_SpeedX(spx), .i_SpeedY(spy), .o_Video(vid[0]), .o_PosX(px[0]), .o_PosY(py[0]),
      .o_HitX(hx[0]), .o_HitY(hy[0]));
   bounce_sprite #(.P_H_VISIBLE(40), .P_V_VISIBLE(30), .P_SIZE(6), .P_WRAP(1'b1)) u1 (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_HBlank(hb), .i_VBlank(vb), .i_HReset(hr), .i_VReset(vr),
      .i_Pause(pause), .i_SpeedX(spx), .i_SpeedY(spy), .o_Video(vid[1]), .o_PosX(px[1]), .o_PosY(py[1]),
      .o_HitX(hx[1]), .o_HitY(hy[1]));
   bounce_sprite u2 (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_HBlank(hb), .i_VBlank(vb), .i_HReset(hr), .i_VReset(vr),
      .i_Pause(pause), .i_SpeedX(spx), .i_SpeedY(spy), .o_Video(vid[2]), .o_PosX(px[2]), .o_PosY(py[2]),
      .o_HitX(hx[2]), .o_HitY(hy[2]));

   task automatic chk(input string nm, input int a, input int e);
      n_cmp++;
      if (a != e) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, a, e, $time);
      end
   endtask

   // one frame of motion on one axis, straight from the bounce/wrap rules
   function automatic void mstep(input int lim, input int sz, input int wrap, input int spd, inout int p, inout int d, output logic hit);
      int n;
      n = (d != 0) ? p + spd : p - spd;
      hit = 1'b0;
      if (spd == 0) return;
      if (wrap != 0) begin
         hit = (n < 0) || (n >= lim);
         p = (n + lim) % lim;
      end else if (d != 0 && n >= lim - sz) begin
         p = lim - sz;
         d = 0;
         hit = 1'b1;
      end else if (d == 0 && n <= 0) begin
         p = 0;
         d = 1;
         hit = 1'b1;
      end else p = n;
   endfunction

   function automatic logic expv(input int i);
      int dx, dy;
      dx = cx - int'(cur[i].x);
      dy = cy - int'(cur[i].y);
      if (W[i] != 0) begin
         dx = (dx + H[i]) % H[i];
         dy = (dy + V[i]) % V[i];
      end
      return dx >= 0 && dx < S[i] && dy >= 0 && dy < S[i];
   endfunction

   task automatic model_reset();
      q.delete();
      pp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mx[i] = (H[i] - S[i]) / 2;
         my[i] = (V[i] - S[i]) / 2;
         mdx[i] = 1;
         mdy[i] = 1;
         cur[i].x = 10'(mx[i]);
         cur[i].y = 10'(my[i]);
         cur[i].hx = 1'b0;
         cur[i].hy = 1'b0;
      end
   endtask

   task automatic push_upd();
      exp3_t e;
      logic a, b;
      for (int i = 0; i < 3; i++) begin
         a = 1'b0;
         b = 1'b0;
         if (!pause && !pp) begin
            mstep(H[i], S[i], W[i], int'(spx), mx[i], mdx[i], a);
            mstep(V[i], S[i], W[i], int'(spy), my[i], mdy[i], b);
         end
         e[i].x = 10'(mx[i]);
         e[i].y = 10'(my[i]);
         e[i].hx = a;
         e[i].hy = b;
      end
      q.push_back(e);
   endtask

   task automatic cyc(input logic h_b, input logic v_b, input logic h_r, input logic v_r, input int x, input int y);
      hb = h_b;
      vb = v_b;
      hr = h_r;
      vr = v_r;
      cx = x;
      cy = y;
      if (v_r) push_upd();
      pp = pause;
      @(posedge clk);
      #1;
   endtask

   task automatic line(input int y, input logic v_b, input logic v_r);
      for (int x = 0; x < 40; x++) cyc(1'b0, v_b, 1'b0, 1'b0, x, y);
      for (int b = 0; b < 8; b++) cyc(1'b1, v_b, b == 3, v_r && b == 5, 0, y);
   endtask

   task automatic frame();
      for (int y = 0; y < 30; y++) line(y, 1'b0, 1'b0);
      line(0, 1'b1, 1'b1);
      line(0, 1'b1, 1'b0);
   endtask

   task automatic fast(input bit rp);
      for (int k = 0; k < 3; k++) begin
         if (rp) pause = ($urandom_range(0, 3) == 0);
         cyc(1'b1, 1'b1, 1'b0, k == 1, 0, 0);
      end
   endtask

   task automatic chk_reset();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d_rst_posx", i), px[i], (H[i] - S[i]) / 2);
         chk($sformatf("u%0d_rst_posy", i), py[i], (V[i] - S[i]) / 2);
         chk($sformatf("u%0d_rst_hitx", i), hx[i], 0);
         chk($sformatf("u%0d_rst_hity", i), hy[i], 0);
      end
   endtask

   initial begin
      logic s_vr, u;
      forever begin
         @(posedge clk);
         s_vr = vr;
         @(negedge clk);
         u = s_vr && rst_n;
         if (u) begin
            chk("sb_depth", q.size(), 1);
            if (q.size() != 0) cur = q.pop_front();
         end
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_posx", i), px[i], cur[i].x);
            chk($sformatf("u%0d_posy", i), py[i], cur[i].y);
            chk($sformatf("u%0d_hitx", i), hx[i], u ? cur[i].hx : 1'b0);
            chk($sformatf("u%0d_hity", i), hy[i], u ? cur[i].hy : 1'b0);
            if (vid_en && !hb && !vb) chk($sformatf("u%0d_video_c%0d_r%0d", i, cx, cy), vid[i], expv(i));
         end
      end
   end

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
      chk_reset();
      rst_n = 1'b1;
      pp = 1'b0;
      vid_en = 1'b1;
      frame();
      spx = 4'd10;
      spy = 4'd0;
      for (int k = 0; k < 31; k++) fast(1'b0);
      spx = 4'd7;
      fast(1'b0);
      chk("u2_edge_posx", px[2], 630);
      fast(1'b0);
      chk("u2_after_edge_posx", px[2], 623);
      spx = 4'd4;
      spy = 4'd4;
      pause = 1'b1;
      for (int k = 0; k < 3; k++) fast(1'b0);
      pause = 1'b0;
      fast(1'b0);
      frame();
      for (int k = 0; k < 200; k++) begin
         spx = 4'($urandom_range(0, 15));
         spy = 4'($urandom_range(0, 15));
         if (k % 25 == 0) begin
            pause = ($urandom_range(0, 3) == 0);
            frame();
         end else fast(1'b1);
      end
      pause = 1'b0;
      line(0, 1'b0, 1'b0);
      for (int x = 0; x < 15; x++) cyc(1'b0, 1'b0, 1'b0, 1'b0, x, 1);
      rst_n = 1'b0;
      vid_en = 1'b0;
      model_reset();
      #1;
      chk_reset();
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
      rst_n = 1'b1;
      pp = 1'b0;
      vid_en = 1'b1;
      spx = 4'd3;
      spy = 4'd5;
      frame();
      frame();
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
      chk("sb_drain", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
